// File: rtl/decim_avg.sv
// Boxcar average-and-dump decimator: averages blocks of 2^LOG2R samples with
// round-half-up and queues each mean in a 2-entry valid/ready output FIFO.
module decim_avg #(
    parameter int WIDTH = 16,
    parameter int LOG2R = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    localparam int ACC_W = WIDTH + LOG2R;
    localparam int CNT_W = (LOG2R > 0) ? LOG2R : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** LOG2R) - 1);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    occ_t                    r_occ;
    logic signed [WIDTH-1:0] r_head;
    logic signed [WIDTH-1:0] r_tail;
    logic                    r_valid;
    logic                    r_overrun;

    logic signed [ACC_W-1:0] w_in_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [WIDTH-1:0] w_result;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_drop;
    occ_t                    w_occ_next;
    logic signed [WIDTH-1:0] w_head_next;
    logic signed [WIDTH-1:0] w_tail_next;

    // A full block of R samples always fits in WIDTH+LOG2R bits.
    always_comb begin
        w_in_ext = {{LOG2R{in_data[WIDTH-1]}}, in_data};
        w_sum    = r_acc + w_in_ext;
    end

    // (sum + R/2) >>> LOG2R folded into the top WIDTH bits plus the carry
    // produced by the half-LSB bit; the rounded mean cannot wrap.
    if (LOG2R > 0) begin : g_round
        always_comb begin
            w_result = w_sum[ACC_W-1 -: WIDTH] + WIDTH'(w_sum[LOG2R-1]);
        end
    end else begin : g_pass
        always_comb begin
            w_result = w_sum;
        end
    end

    always_comb begin
        w_push = in_valid && (r_cnt == CNT_LAST);
        w_pop  = r_valid && out_ready;
    end

    always_comb begin
        w_occ_next  = r_occ;
        w_head_next = r_head;
        w_tail_next = r_tail;
        w_drop      = 1'b0;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_push) begin
                    w_head_next = w_result;
                    w_occ_next  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({w_push, w_pop})
                    2'b10: begin
                        w_tail_next = w_result;
                        w_occ_next  = OCC_FULL;
                    end
                    2'b01: w_occ_next = OCC_EMPTY;
                    2'b11: w_head_next = w_result;
                    default: ;
                endcase
            end
            OCC_FULL: begin
                case ({w_push, w_pop})
                    2'b10: w_drop = 1'b1;
                    2'b01: begin
                        w_head_next = r_tail;
                        w_occ_next  = OCC_ONE;
                    end
                    2'b11: begin
                        w_head_next = r_tail;
                        w_tail_next = w_result;
                    end
                    default: ;
                endcase
            end
            default: w_occ_next = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_occ     <= OCC_EMPTY;
            r_head    <= '0;
            r_tail    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_occ     <= OCC_EMPTY;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (in_valid) begin
                if (w_push) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            r_occ   <= w_occ_next;
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_valid <= (w_occ_next != OCC_EMPTY);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_data  = r_head;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule
